pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Consumes the decoder's per-instruction control bits at ID and keeps its own shadow of each in-flight instruction's register and control fields.
- Generates pipeline-register enables and flushes, forwarding selects, and the data-memory request handshake.
- Stalls on load-use hazards and on slow memory; flushes on taken branches; aborts a memory access on timeout.

Parameters:
- MEM_TIMEOUT, 64: max cycles a data-memory request may wait for ack before abort.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1_addr  in  5  ID source 1
- i_id_rs2_addr  in  5  ID source 2
- i_id_uses_rs2  in  1  ID reads rs2 (R-type, store, branch)
- i_id_rd_addr  in  5  ID destination
- i_id_regwrite  in  1  decoder regwrite
- i_id_memread  in  1  decoder memread
- i_id_memwrite  in  1  decoder memwrite
- i_ex_branch_taken  in  1  branch in EX resolved taken
- i_dmem_ack  in  1  data memory completes current request
- o_dmem_req  out  1  data-memory request for the MEM-stage instruction
- o_pc_en  out  1  PC register update enable
- o_ifid_en  out  1  IF/ID register enable
- o_ifid_flush  out  1  IF/ID loads bubble
- o_idex_en  out  1  ID/EX register enable
- o_idex_flush  out  1  ID/EX loads bubble
- o_exmem_en  out  1  EX/MEM register enable
- o_memwb_bubble  out  1  MEM/WB loads bubble (regwrite suppressed)
- o_fwd_a  out  2  ALU operand A select
- o_fwd_b  out  2  ALU operand B select
- o_mem_err  out  1  one-cycle pulse on memory timeout
- o_stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Shadow slots EX, MEM, WB hold {valid, rs1, rs2, rd, regwrite, memread, memaccess}.
  - Slots shift EX→MEM→WB on each cycle the pipeline advances.
  - EX loads the ID fields, or a bubble (valid=0) when o_idex_flush is asserted.
- Reset: all slots invalid, FSM=RUN, timeout counter=0, stall counter=0.
  - Outputs after reset: o_pc_en=o_ifid_en=o_idex_en=o_exmem_en=1; all flushes, bubble, o_dmem_req, o_mem_err=0; fwd=00.
  - Reset asserted mid-wait drops o_dmem_req immediately (asynchronously).
- Forwarding, evaluated against the EX-slot rs1/rs2:
  - 10 when MEM slot is valid, regwrite, rd!=0 and rd==rs.
  - Otherwise 01 when WB slot matches under the same conditions.
  - Otherwise 00.
  - MEM has priority over WB.
- Load-use hazard: EX slot valid && memread && rd!=0 && (rd==i_id_rs1_addr || (i_id_uses_rs2 && rd==i_id_rs2_addr)) && i_id_valid.
  - Response: o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for exactly one cycle.
- Taken branch (i_ex_branch_taken): o_ifid_flush=1, o_idex_flush=1, PC advances to target.
  - Takes priority over load-use; the stalled ID instruction is discarded anyway.
- FSM states:
  - RUN: o_dmem_req = MEM slot valid && memaccess.
    - req && i_dmem_ack in the same cycle → zero-wait, no stall.
    - req && !ack → WAIT; the same cycle is already a stall.
  - WAIT: o_dmem_req=1. All enables are 0 and o_memwb_bubble=1; shadow slots hold.
    - ack → RUN. The pipeline advances in that cycle and MEM/WB captures the load result.
    - Timeout counter reaches MEM_TIMEOUT-1 without ack → ABORT.
  - ABORT: one cycle with o_mem_err=1, o_dmem_req=0, o_memwb_bubble=1.
    - The MEM slot is invalidated; the pipeline advances; → RUN.
- Timeout counter clears on entry to WAIT and increments each WAIT cycle.
- Memory stall beats branch and load-use: everything is frozen.
  - A pending branch flush or load-use stall is re-evaluated once the pipeline releases.
  - Nothing is lost, because the EX slot and inputs are held.
- o_stall_cnt increments (saturating at all-ones) on any cycle with o_pc_en=0 that is not a taken-branch cycle.
- x0 is never a hazard and never forwarded.
- Branches use the regfile for rs1/rs2 via forwarding like ALU ops.

Decomposition:
- Shared package core_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - FSM state encoding RUN/WAIT/ABORT
  - opcode constants shared with the decoder
- One sub-module, hazard_fwd_unit: purely combinational forwarding-select and load-use detection from the slot fields.
- Sequencing FSM, slot registers and counters stay in pipeline_ctrl.

Test Plan:
1. lw x5 in EX, ID add x6,x5,x1 → one cycle o_pc_en=0, o_idex_flush=1. Next cycle o_fwd_a=01 when add reaches EX. o_stall_cnt=1.
2. add x3 in MEM, add x3 in WB, EX reads x3 on rs2 → o_fwd_b=10. With rd=x0 in both slots → o_fwd_b=00.
3. sw reaches MEM, i_dmem_ack low for 3 cycles then high → o_dmem_req high 4 cycles, all enables 0 for 3 cycles, resume on ack cycle, o_stall_cnt=3.
4. Taken branch in EX while MEM waits 2 cycles → no flush during wait. o_ifid_flush=o_idex_flush=1 on the ack cycle only.
5. MEM_TIMEOUT=4, ack never asserted → 4 WAIT cycles, then o_mem_err pulse 1 cycle, MEM slot bubbled, FSM back to RUN.
6. i_rst_n low during WAIT → o_dmem_req=0 immediately, all slots invalid, o_stall_cnt=0, enables=1 after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: forwarding selects, controller
// FSM encoding, decoder opcodes and the shadow-slot record.
package core_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } ctrl_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Per-instruction fields tracked by the controller; valid is kept apart.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic       memaccess;
    } slot_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding-select and load-use detection from the shadow
// slot fields and the instruction currently sitting in ID.
module hazard_fwd_unit
    import core_pkg::*;
(
    input  logic       ex_vld,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       mem_vld,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       wb_vld,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       load_use
);

    // x0 is hardwired zero, so a write to it never produces a result to bypass.
    function automatic logic hit(input logic vld, input logic rw,
                                 input logic [4:0] rd, input logic [4:0] rs);
        return vld && rw && (rd != 5'd0) && (rd == rs);
    endfunction

    always_comb begin
        fwd_a = FWD_REG;
        if (ex_vld && hit(mem_vld, mem_regwrite, mem_rd, ex_rs1))
            fwd_a = FWD_MEM;
        else if (ex_vld && hit(wb_vld, wb_regwrite, wb_rd, ex_rs1))
            fwd_a = FWD_WB;
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (ex_vld && hit(mem_vld, mem_regwrite, mem_rd, ex_rs2))
            fwd_b = FWD_MEM;
        else if (ex_vld && hit(wb_vld, wb_regwrite, wb_rd, ex_rs2))
            fwd_b = FWD_WB;
    end

    assign load_use = id_valid && ex_vld && ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: shadow slots for EX/MEM/WB, pipeline
// enables/flushes, forwarding selects and the data-memory handshake FSM.
module pipeline_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_id_rd_addr,
    input  logic             i_id_regwrite,
    input  logic             i_id_memread,
    input  logic             i_id_memwrite,
    input  logic             i_ex_branch_taken,
    input  logic             i_dmem_ack,
    output logic             o_dmem_req,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_bubble,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             vld_p0, vld_p1, vld_p2;
    slot_t            slot_p0, slot_p1, slot_p2;
    logic             lu_hazard;
    logic             mem_freeze, advance, br_flush, lu_stall;
    logic             slot_unused;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_fwd_unit u_hazard (
        .ex_vld       (vld_p0),
        .ex_rs1       (slot_p0.rs1),
        .ex_rs2       (slot_p0.rs2),
        .ex_rd        (slot_p0.rd),
        .ex_memread   (slot_p0.memread),
        .mem_vld      (vld_p1),
        .mem_rd       (slot_p1.rd),
        .mem_regwrite (slot_p1.regwrite),
        .wb_vld       (vld_p2),
        .wb_rd        (slot_p2.rd),
        .wb_regwrite  (slot_p2.regwrite),
        .id_valid     (i_id_valid),
        .id_rs1       (i_id_rs1_addr),
        .id_rs2       (i_id_rs2_addr),
        .id_uses_rs2  (i_id_uses_rs2),
        .fwd_a        (o_fwd_a),
        .fwd_b        (o_fwd_b),
        .load_use     (lu_hazard)
    );

    // A slow memory freezes everything; branch and load-use only act once it releases.
    assign o_dmem_req = (state == WAIT) || ((state == RUN) && vld_p1 && slot_p1.memaccess);
    assign mem_freeze = ((state == RUN) && o_dmem_req && !i_dmem_ack) ||
                        ((state == WAIT) && !i_dmem_ack);
    assign advance    = !mem_freeze;
    assign br_flush   = advance && i_ex_branch_taken;
    assign lu_stall   = advance && lu_hazard && !i_ex_branch_taken;

    assign o_pc_en        = advance && !lu_stall;
    assign o_ifid_en      = advance && !lu_stall;
    assign o_ifid_flush   = br_flush;
    assign o_idex_en      = advance;
    assign o_idex_flush   = br_flush || lu_stall;
    assign o_exmem_en     = advance;
    assign o_memwb_bubble = mem_freeze || (state == ABORT);
    assign o_mem_err      = (state == ABORT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= RUN;
            tmo_cnt     <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (o_dmem_req && !i_dmem_ack) begin
                        state   <= WAIT;
                        tmo_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (i_dmem_ack)
                        state <= RUN;
                    else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1))
                        state <= ABORT;
                    else
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                default: state <= RUN;
            endcase
            if (advance) begin
                vld_p0 <= i_id_valid && !o_idex_flush;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1 && (state != ABORT);
            end
            if (!o_pc_en)
                o_stall_cnt <= sat_inc(o_stall_cnt);
        end
    end

    // ID -> EX -> MEM -> WB shadow fields
    always_ff @(posedge i_clk) begin
        if (advance) begin
            slot_p0 <= '{rs1: i_id_rs1_addr, rs2: i_id_rs2_addr, rd: i_id_rd_addr,
                         regwrite: i_id_regwrite, memread: i_id_memread,
                         memaccess: i_id_memread || i_id_memwrite};
            slot_p1 <= slot_p0;
            slot_p2 <= slot_p1;
        end
    end

    assign slot_unused = ^{slot_p2.rs1, slot_p2.rs2, slot_p2.memread, slot_p2.memaccess};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl with a small expected-output queue;
// hand-written sequences cover counter saturation and reset mid-wait.
module tb_pipeline_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_id_valid, i_id_uses_rs2, i_id_regwrite, i_id_memread, i_id_memwrite;
    logic [4:0]       i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
    logic             i_ex_branch_taken, i_dmem_ack;
    logic             o_dmem_req, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush;
    logic             o_exmem_en, o_memwb_bubble, o_mem_err;
    logic [1:0]       o_fwd_a, o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt;

    always #5 i_clk = ~i_clk;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_valid(i_id_valid), .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_id_uses_rs2(i_id_uses_rs2), .i_id_rd_addr(i_id_rd_addr), .i_id_regwrite(i_id_regwrite),
        .i_id_memread(i_id_memread), .i_id_memwrite(i_id_memwrite),
        .i_ex_branch_taken(i_ex_branch_taken), .i_dmem_ack(i_dmem_ack),
        .o_dmem_req(o_dmem_req), .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en),
        .o_ifid_flush(o_ifid_flush), .o_idex_en(o_idex_en), .o_idex_flush(o_idex_flush),
        .o_exmem_en(o_exmem_en), .o_memwb_bubble(o_memwb_bubble),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_mem_err(o_mem_err), .o_stall_cnt(o_stall_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mw;
    } ins_t;

    typedef struct packed {
        logic             req;
        logic [3:0]       en;   // {pc, ifid, idex, exmem}
        logic [1:0]       fl;   // {ifid_flush, idex_flush}
        logic             bub;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef struct {
        string nm;
        ins_t  ins;
        logic  br;
        logic  ack;
        out_t  exp;
    } vec_t;

    localparam logic [3:0] EN_ALL  = 4'b1111;
    localparam logic [3:0] EN_LU   = 4'b0011;
    localparam logic [3:0] EN_NONE = 4'b0000;

    vec_t tbl[$];
    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic ins_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        ins_t r;
        r.v = 1'b1; r.rs1 = rs1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.mr = mr; r.mw = mw;
        return r;
    endfunction

    function automatic out_t eo(input logic req, input logic [3:0] en, input logic [1:0] fl,
                                input logic bub, input logic [1:0] fa, input logic [1:0] fb,
                                input logic err, input int cnt);
        out_t r;
        r.req = req; r.en = en; r.fl = fl; r.bub = bub;
        r.fa = fa; r.fb = fb; r.err = err; r.cnt = CNT_W'(cnt);
        return r;
    endfunction

    function automatic out_t nrm(input int cnt);
        return eo(1'b0, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, cnt);
    endfunction

    function automatic out_t frz(input int cnt);
        return eo(1'b1, EN_NONE, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, cnt);
    endfunction

    function automatic void add(input string nm, input ins_t ins, input logic br,
                                input logic ack, input out_t e);
        vec_t v;
        v.nm = nm; v.ins = ins; v.br = br; v.ack = ack; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic out_t actual();
        out_t r;
        r.req = o_dmem_req;
        r.en  = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en};
        r.fl  = {o_ifid_flush, o_idex_flush};
        r.bub = o_memwb_bubble;
        r.fa  = o_fwd_a;
        r.fb  = o_fwd_b;
        r.err = o_mem_err;
        r.cnt = o_stall_cnt;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input ins_t ins, input logic br, input logic ack);
        i_id_valid = ins.v;     i_id_rs1_addr = ins.rs1; i_id_rs2_addr = ins.rs2;
        i_id_uses_rs2 = ins.u2; i_id_rd_addr = ins.rd;   i_id_regwrite = ins.rw;
        i_id_memread = ins.mr;  i_id_memwrite = ins.mw;
        i_ex_branch_taken = br; i_dmem_ack = ack;
    endtask

    task automatic cycle(input ins_t ins, input logic br, input logic ack);
        @(posedge i_clk); #1;
        drive(ins, br, ack);
        @(negedge i_clk);
    endtask

    task automatic run_table();
        foreach (tbl[k]) begin
            @(posedge i_clk); #1;
            drive(tbl[k].ins, tbl[k].br, tbl[k].ack);
            exp_q.push_back(tbl[k].exp);
            @(negedge i_clk);
            check(tbl[k].nm, 32'(actual()), 32'(exp_q.pop_front()));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        ins_t idle, lw5, add6, i9, a3, a7, a8, z0, a7z, sw, lw4, beq, a9, lw7, a8b;
        idle = '0;
        lw5  = mk(5'd2, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        add6 = mk(5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        i9   = mk(5'd1, 5'd5, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        a3   = mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        a7   = mk(5'd4, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        a8   = mk(5'd3, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        z0   = mk(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        a7z  = mk(5'd4, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        sw   = mk(5'd2, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        lw4  = mk(5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        beq  = mk(5'd2, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        a9   = mk(5'd7, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        lw7  = mk(5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        a8b  = mk(5'd7, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);

        i_rst_n = 1'b0;
        drive(idle, 1'b0, 1'b0);
        do_reset();
        add("rst.idle", idle, 1'b0, 1'b0, nrm(0));
        run_table();

        // load-use stall, then WB forwarding once the add reaches EX
        do_reset();
        add("t1.lw",    lw5,  1'b0, 1'b0, nrm(0));
        add("t1.stall", add6, 1'b0, 1'b0, eo(1'b0, EN_LU, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 0));
        add("t1.rel",   add6, 1'b0, 1'b1, eo(1'b1, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1));
        add("t1.fwd",   idle, 1'b0, 1'b0, eo(1'b0, EN_ALL, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1));
        run_table();

        do_reset();
        add("t1b.lw",    lw5,  1'b0, 1'b0, nrm(0));
        add("t1b.nors2", i9,   1'b0, 1'b0, nrm(0));
        add("t1b.fwdb",  idle, 1'b0, 1'b1, eo(1'b1, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 0));
        run_table();

        do_reset();
        add("t1c.lw0", mk(5'd2, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, nrm(0));
        add("t1c.x0",  mk(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, nrm(0));
        run_table();

        // forwarding priority MEM over WB, then WB alone
        do_reset();
        add("t2.r1",  a3,   1'b0, 1'b0, nrm(0));
        add("t2.r2",  a3,   1'b0, 1'b0, nrm(0));
        add("t2.r3",  a7,   1'b0, 1'b0, nrm(0));
        add("t2.mem", a8,   1'b0, 1'b0, eo(1'b0, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 0));
        add("t2.wb",  idle, 1'b0, 1'b0, eo(1'b0, EN_ALL, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 0));
        run_table();

        do_reset();
        add("t2z.r1", z0,   1'b0, 1'b0, nrm(0));
        add("t2z.r2", z0,   1'b0, 1'b0, nrm(0));
        add("t2z.r3", a7z,  1'b0, 1'b0, nrm(0));
        add("t2z.x0", idle, 1'b0, 1'b0, nrm(0));
        run_table();

        // store waits three cycles for ack
        do_reset();
        add("t3.sw",    sw,   1'b0, 1'b0, nrm(0));
        add("t3.ex",    idle, 1'b0, 1'b0, nrm(0));
        add("t3.w0",    idle, 1'b0, 1'b0, frz(0));
        add("t3.w1",    idle, 1'b0, 1'b0, frz(1));
        add("t3.w2",    idle, 1'b0, 1'b0, frz(2));
        add("t3.ack",   idle, 1'b0, 1'b1, eo(1'b1, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3));
        add("t3.after", idle, 1'b0, 1'b0, nrm(3));
        run_table();

        // taken branch held off by a memory wait
        do_reset();
        add("t4.lw",    lw4,  1'b0, 1'b0, nrm(0));
        add("t4.beq",   beq,  1'b0, 1'b0, nrm(0));
        add("t4.w0",    a9,   1'b1, 1'b0, frz(0));
        add("t4.w1",    a9,   1'b1, 1'b0, frz(1));
        add("t4.ack",   a9,   1'b1, 1'b1, eo(1'b1, EN_ALL, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2));
        add("t4.after", idle, 1'b0, 1'b0, nrm(2));
        run_table();

        // branch beats load-use and is not counted as a stall
        do_reset();
        add("t4b.lw",  lw5,  1'b0, 1'b0, nrm(0));
        add("t4b.br",  add6, 1'b1, 1'b0, eo(1'b0, EN_ALL, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 0));
        add("t4b.mem", idle, 1'b0, 1'b1, eo(1'b1, EN_ALL, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0));
        run_table();

        // timeout abort; the aborted load must not forward from WB
        do_reset();
        add("t5.lw",    lw7,  1'b0, 1'b0, nrm(0));
        add("t5.ex",    idle, 1'b0, 1'b0, nrm(0));
        add("t5.f0",    a8b,  1'b0, 1'b0, frz(0));
        add("t5.f1",    a8b,  1'b0, 1'b0, frz(1));
        add("t5.f2",    a8b,  1'b0, 1'b0, frz(2));
        add("t5.f3",    a8b,  1'b0, 1'b0, frz(3));
        add("t5.f4",    a8b,  1'b0, 1'b0, frz(4));
        add("t5.abort", a8b,  1'b0, 1'b0, eo(1'b0, EN_ALL, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 5));
        add("t5.post",  idle, 1'b0, 1'b0, nrm(5));
        add("t5.run",   idle, 1'b0, 1'b0, nrm(5));
        run_table();

        // three more aborts add 15 stalls: counter must stick at all-ones
        for (int n = 0; n < 3; n++) begin
            cycle(lw7, 1'b0, 1'b0);
            for (int c = 0; c < 8; c++) cycle(idle, 1'b0, 1'b0);
        end
        check("t5.sat", 32'(o_stall_cnt), 32'(4'hF));
        check("t5.sat_err", 32'(o_mem_err), 32'd0);

        // reset asserted while waiting on memory
        do_reset();
        add("t6.sw", sw,   1'b0, 1'b0, nrm(0));
        add("t6.ex", idle, 1'b0, 1'b0, nrm(0));
        add("t6.w0", idle, 1'b0, 1'b0, frz(0));
        add("t6.w1", idle, 1'b0, 1'b0, frz(1));
        run_table();
        #2 i_rst_n = 1'b0;
        #1;
        check("t6.req_drop", 32'(o_dmem_req), 32'd0);
        check("t6.cnt_clr", 32'(o_stall_cnt), 32'd0);
        check("t6.en", 32'({o_pc_en, o_ifid_en, o_idex_en, o_exmem_en}), 32'(EN_ALL));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        add("t6.post", idle, 1'b0, 1'b0, nrm(0));
        run_table();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
